perceptron_trainer: RTL

Training sequencer for a single perceptron neuron. Holds a small sample memory of argument vectors and target values, and replays it epoch by epoch. For each sample it drives the perceptron argument channel, compares the result with the target, returns the error, and drains the propagate channel. Training stops at the first mistake-free epoch (converged) or after MAX_EPOCHS epochs.

---
 rtl/perceptron_trainer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/perceptron_trainer.sv
//------------------------------------------------------------------------------
// perceptron_trainer : epoch-by-epoch training sequencer for one perceptron
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module perceptron_trainer #(
   parameter int N          = 2,
   parameter int DEPTH      = 4,
   parameter int MAX_EPOCHS = 16,
   localparam int EW = $clog2(MAX_EPOCHS + 1),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load_valid,
   input  logic [N*8+7:0]    i_load_data,
   output logic              o_load_ready,
   input  logic              i_start,
   input  logic              i_clear,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_converged,
   output logic [EW-1:0]     o_epochs,
   output logic [CW-1:0]     o_mistakes,
   output logic              o_train,
   output logic              o_argument_valid,
   output logic [N*8-1:0]    o_argument_data,
   input  logic              i_argument_ready,
   input  logic              i_result_valid,
   input  logic [7:0]        i_result_data,
   output logic              o_result_ready,
   output logic              o_error_valid,
   output logic [15:0]       o_error_data,
   input  logic              i_error_ready,
   input  logic              i_propagate_valid,
   input  logic [N*16-1:0]   i_propagate_data,
   output logic              o_propagate_ready
);

   localparam int IW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARG  = 3'd1,
      S_RES  = 3'd2,
      S_ERR  = 3'd3,
      S_PROP = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t              r_state, w_next;
   logic [N*8+7:0]      r_mem [DEPTH];
   logic [CW-1:0]       r_count;
   logic [IW-1:0]       r_idx;
   logic [IW-1:0]       w_idx_inc;
   logic [N*8-1:0]      r_arg;
   logic [15:0]         r_err;
   logic [CW-1:0]       r_mistakes;
   logic [EW-1:0]       r_epochs;
   logic                r_converged;
   logic                w_load, w_begin, w_last, w_stop, w_prop_hs;
   logic [7:0]          w_target;
   logic [8:0]          w_diff;
   logic                w_unused;

   assign w_unused  = ^i_propagate_data;
   assign w_load    = i_load_valid && o_load_ready;
   assign w_begin   = i_start && !i_clear && (r_count != '0) &&
                      ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_idx_inc = r_idx + 1'b1;
   assign w_last    = (CW'(r_idx) + 1'b1) >= r_count;
   assign w_stop    = (r_mistakes == '0) || ((r_epochs + 1'b1) == EW'(MAX_EPOCHS));
   assign w_prop_hs = (r_state == S_PROP) && i_propagate_valid;
   assign w_target  = r_mem[r_idx][N*8 +: 8];
   // 9-bit difference keeps the borrow so the sign survives extension
   assign w_diff    = {1'b0, w_target} - {1'b0, i_result_data};

   always_comb begin
      w_next            = r_state;
      o_load_ready      = 1'b0;
      o_busy            = 1'b1;
      o_done            = 1'b0;
      o_train           = 1'b1;
      o_argument_valid  = 1'b0;
      o_result_ready    = 1'b0;
      o_error_valid     = 1'b0;
      o_propagate_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_busy       = 1'b0;
            o_train      = 1'b0;
            o_load_ready = (r_count < CW'(DEPTH));
            if (w_begin) w_next = S_ARG;
         end
         S_ARG: begin
            o_argument_valid = 1'b1;
            if (i_argument_ready) w_next = S_RES;
         end
         S_RES: begin
            o_result_ready = 1'b1;
            if (i_result_valid) w_next = S_ERR;
         end
         S_ERR: begin
            o_error_valid = 1'b1;
            if (i_error_ready) w_next = S_PROP;
         end
         S_PROP: begin
            o_propagate_ready = 1'b1;
            if (i_propagate_valid) w_next = (w_last && w_stop) ? S_DONE : S_ARG;
         end
         S_DONE: begin
            o_busy  = 1'b0;
            o_done  = 1'b1;
            o_train = 1'b0;
            if (i_clear)      w_next = S_IDLE;
            else if (w_begin) w_next = S_ARG;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (w_load) r_mem[r_count[IW-1:0]] <= i_load_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_count     <= '0;
         r_idx       <= '0;
         r_arg       <= '0;
         r_err       <= '0;
         r_mistakes  <= '0;
         r_epochs    <= '0;
         r_converged <= 1'b0;
      end else begin
         r_state <= w_next;
         if (i_clear && ((r_state == S_IDLE) || (r_state == S_DONE)))
            r_count <= '0;
         else if (w_load)
            r_count <= r_count + 1'b1;

         if (w_begin) begin
            r_idx       <= '0;
            r_mistakes  <= '0;
            r_epochs    <= '0;
            r_converged <= 1'b0;
            r_arg       <= r_mem[0][N*8-1:0];
         end

         if ((r_state == S_RES) && i_result_valid) begin
            r_err <= {{7{w_diff[8]}}, w_diff};
            if (i_result_data != w_target) r_mistakes <= r_mistakes + 1'b1;
         end

         if (w_prop_hs) begin
            if (!w_last) begin
               r_idx <= w_idx_inc;
               r_arg <= r_mem[w_idx_inc][N*8-1:0];
            end else begin
               if (r_epochs != EW'(MAX_EPOCHS)) r_epochs <= r_epochs + 1'b1;
               if (w_stop) begin
                  r_converged <= (r_mistakes == '0);
               end else begin
                  r_idx      <= '0;
                  r_mistakes <= '0;
                  r_arg      <= r_mem[0][N*8-1:0];
               end
            end
         end
      end
   end

   assign o_converged     = r_converged;
   assign o_epochs        = r_epochs;
   assign o_mistakes      = r_mistakes;
   assign o_argument_data = r_arg;
   assign o_error_data    = r_err;

endmodule

`default_nettype wire
